// File: rtl/mul_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit.
// Define MULDIV_DIV_EN to build the divider; otherwise DIV completes in 1 cycle with zero results.
module mul_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              MUL,
  input  logic              DIV,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] ZHI,
  output logic [DATA_W-1:0] ZLO,
  output logic              Busy,
  output logic              Done,
  output logic              DivByZero
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W-1);

  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [CW-1:0]     r_cnt;
  logic [DATA_W:0]   r_acc;
  logic [DATA_W-1:0] r_q;
  logic [DATA_W-1:0] r_m;
  logic              r_qm1;
  logic [DATA_W-1:0] r_zhi, r_zlo;
  logic              r_busy, r_done, r_dz;

  logic              w_last;
  logic [DATA_W:0]   w_msx, w_bsum, w_bacc;
  logic [DATA_W-1:0] w_bq;
  logic              w_ld, w_dz;
  logic [DATA_W-1:0] w_zhi, w_zlo;

`ifdef MULDIV_DIV_EN
  logic              r_sa, r_sb;
  logic [DATA_W:0]   w_dsh, w_dtry, w_dacc;
  logic [DATA_W-1:0] w_dq, w_absa, w_absb;

  assign w_absa = A[DATA_W-1] ? -A : A;
  assign w_absb = B[DATA_W-1] ? -B : B;
  assign w_dsh  = {r_acc[DATA_W-1:0], r_q[DATA_W-1]};
  assign w_dtry = w_dsh - {1'b0, r_m};
  assign w_dacc = w_dtry[DATA_W] ? w_dsh : w_dtry;
  assign w_dq   = {r_q[DATA_W-2:0], ~w_dtry[DATA_W]};
`endif

  assign w_last = (r_cnt == LAST);
  assign w_msx  = {r_m[DATA_W-1], r_m};

  always_comb begin
    w_bsum = r_acc;
    case ({r_q[0], r_qm1})
      2'b01:   w_bsum = r_acc + w_msx;
      2'b10:   w_bsum = r_acc - w_msx;
      default: w_bsum = r_acc;
    endcase
  end

  assign w_bacc = {w_bsum[DATA_W], w_bsum[DATA_W:1]};
  assign w_bq   = {w_bsum[0], r_q[DATA_W-1:1]};

  always_comb begin
    w_next = r_state;
    w_ld   = 1'b0;
    w_zhi  = '0;
    w_zlo  = '0;
    w_dz   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (MUL) begin
          w_next = S_MUL;
        end else if (DIV) begin
`ifdef MULDIV_DIV_EN
          if (B == '0) begin
            w_next = S_DONE;
            w_ld   = 1'b1;
            w_zhi  = A;
            w_zlo  = '1;
            w_dz   = 1'b1;
          end else begin
            w_next = S_DIV;
          end
`else
          w_next = S_DONE;
          w_ld   = 1'b1;
`endif
        end
      end
      S_MUL: begin
        if (w_last) begin
          w_next = S_DONE;
          w_ld   = 1'b1;
          w_zhi  = w_bacc[DATA_W-1:0];
          w_zlo  = w_bq;
        end
      end
`ifdef MULDIV_DIV_EN
      S_DIV: begin
        if (w_last) w_next = S_FIX;
      end
      S_FIX: begin
        w_next = S_DONE;
        w_ld   = 1'b1;
        w_zlo  = (r_sa ^ r_sb) ? -r_q : r_q;
        w_zhi  = r_sa ? -r_acc[DATA_W-1:0]
                      : r_acc[DATA_W-1:0];
      end
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_q    <= '0;
      r_m    <= '0;
      r_qm1  <= 1'b0;
      r_zhi  <= '0;
      r_zlo  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dz   <= 1'b0;
`ifdef MULDIV_DIV_EN
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
`endif
    end else begin
      r_busy <= (w_next != S_IDLE);
      r_done <= (w_next == S_DONE);
      r_dz   <= w_dz;
      if (w_ld) begin
        r_zhi <= w_zhi;
        r_zlo <= w_zlo;
      end
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_acc <= '0;
          r_qm1 <= 1'b0;
          if (MUL) begin
            r_m <= A;
            r_q <= B;
`ifdef MULDIV_DIV_EN
          end else if (DIV) begin
            r_m  <= w_absb;
            r_q  <= w_absa;
            r_sa <= A[DATA_W-1];
            r_sb <= B[DATA_W-1];
`endif
          end
        end
        S_MUL: begin
          r_acc <= w_bacc;
          r_q   <= w_bq;
          r_qm1 <= r_q[0];
          r_cnt <= r_cnt + 1'b1;
        end
`ifdef MULDIV_DIV_EN
        S_DIV: begin
          r_acc <= w_dacc;
          r_q   <= w_dq;
          r_cnt <= r_cnt + 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign ZHI       = r_zhi;
  assign ZLO       = r_zlo;
  assign Busy      = r_busy;
  assign Done      = r_done;
  assign DivByZero = r_dz;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit (both MULDIV_DIV_EN builds).
module tb_mul_div_unit;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        MUL = 1'b0;
  logic        DIV = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] ZHI, ZLO;
  logic        Busy, Done, DivByZero;

  int n_chk = 0;
  int n_err = 0;

  mul_div_unit #(.DATA_W(32)) dut (
    .Clock(Clock), .Reset(Reset),
    .MUL(MUL), .DIV(DIV),
    .A(A), .B(B),
    .ZHI(ZHI), .ZLO(ZLO),
    .Busy(Busy), .Done(Done),
    .DivByZero(DivByZero)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        m;
    logic        d;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] zhi;
    logic [31:0] zlo;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t v[12];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where Done is seen.
  task automatic run_op(input logic m, input logic d,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        output int lat, output int bn);
    bit got;
    MUL = m; DIV = d; A = a; B = b;
    @(posedge Clock); #1;
    MUL = 1'b0; DIV = 1'b0;
    A = $urandom; B = $urandom;
    lat = 0; bn = 0; got = 1'b0;
    while (lat < 100 && !got) begin
      @(negedge Clock);
      lat++;
      if (Busy) bn++;
      if (Done) got = 1'b1;
    end
  endtask

  initial begin
    int lat, bn, ndone, nbusy;
    logic [31:0] en_zhi, en_zlo;

    v[0]  = '{1'b1, 1'b0, 32'd7, 32'hFFFFFFFD,
              32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
    v[1]  = '{1'b1, 1'b0, 32'h80000000, 32'h80000000,
              32'h40000000, 32'h00000000, 1'b0, 33};
    v[2]  = '{1'b1, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF,
              32'h3FFFFFFF, 32'h00000001, 1'b0, 33};
    v[3]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'h0, 32'h1, 1'b0, 33};
    v[4]  = '{1'b1, 1'b0, 32'h00012345, 32'h00001000,
              32'h0, 32'h12345000, 1'b0, 33};
    v[5]  = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'd2,
              DIV_EN ? 32'hFFFFFFFF : 32'h0,
              DIV_EN ? 32'hFFFFFFFD : 32'h0,
              1'b0, DIV_EN ? 34 : 1};
    v[6]  = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF,
              32'h0,
              DIV_EN ? 32'h80000000 : 32'h0,
              1'b0, DIV_EN ? 34 : 1};
    v[7]  = '{1'b0, 1'b1, 32'd5, 32'd0,
              DIV_EN ? 32'd5 : 32'h0,
              DIV_EN ? 32'hFFFFFFFF : 32'h0,
              DIV_EN, 1};
    v[8]  = '{1'b1, 1'b0, 32'd3, 32'd4,
              32'h0, 32'd12, 1'b0, 33};
    v[9]  = '{1'b0, 1'b1, 32'd100, 32'hFFFFFFF9,
              DIV_EN ? 32'd2 : 32'h0,
              DIV_EN ? 32'hFFFFFFF2 : 32'h0,
              1'b0, DIV_EN ? 34 : 1};
    v[10] = '{1'b0, 1'b1, 32'h7FFFFFFF, 32'h80000000,
              DIV_EN ? 32'h7FFFFFFF : 32'h0,
              32'h0, 1'b0, DIV_EN ? 34 : 1};
    v[11] = '{1'b1, 1'b0, 32'h0000FFFF, 32'hFFFF0000,
              32'hFFFFFFFF, 32'h00010000, 1'b0, 33};

    repeat (3) @(negedge Clock);
    chk("rst_zhi", {32'h0, ZHI}, 64'h0);
    chk("rst_zlo", {32'h0, ZLO}, 64'h0);
    chk("rst_flags", {61'h0, Busy, Done, DivByZero}, 64'h0);
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    chk("idle_no_done", {63'h0, Done | Busy}, 64'h0);

    for (int i = 0; i < 12; i++) begin
      run_op(v[i].m, v[i].d, v[i].a, v[i].b, lat, bn);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(v[i].lat));
      chk($sformatf("v%0d_busy", i), 64'(bn), 64'(v[i].lat));
      chk($sformatf("v%0d_zhi", i), {32'h0, ZHI}, {32'h0, v[i].zhi});
      chk($sformatf("v%0d_zlo", i), {32'h0, ZLO}, {32'h0, v[i].zlo});
      chk($sformatf("v%0d_dz", i), {63'h0, DivByZero}, {63'h0, v[i].dz});
      @(negedge Clock);
      chk($sformatf("v%0d_after", i),
          {61'h0, Busy, Done, DivByZero}, 64'h0);
    end

    // MUL+DIV together, plus a DIV pulse mid-operation
    MUL = 1'b1; DIV = 1'b1; A = 32'd6; B = 32'd3;
    @(posedge Clock); #1;
    MUL = 1'b0; DIV = 1'b0;
    lat = 0; ndone = 0;
    while (lat < 100 && ndone == 0) begin
      @(negedge Clock);
      lat++;
      if (lat == 10) begin
        DIV = 1'b1; A = 32'd50; B = 32'd5;
        @(posedge Clock); #1;
        DIV = 1'b0;
      end else if (Done) begin
        ndone++;
      end
    end
    chk("both_lat", 64'(lat), 64'd33);
    chk("both_zlo", {32'h0, ZLO}, 64'd18);
    chk("both_zhi", {32'h0, ZHI}, 64'd0);
    ndone = 0;
    repeat (45) begin
      @(negedge Clock);
      if (Done) ndone++;
    end
    chk("no_second_done", 64'(ndone), 64'd0);

    // Reset aborts a running MUL
    run_op(1'b1, 1'b0, 32'd3, 32'd4, lat, bn);
    @(negedge Clock);
    MUL = 1'b1; A = 32'd9; B = 32'd9;
    @(posedge Clock); #1;
    MUL = 1'b0;
    repeat (15) @(negedge Clock);
    chk("pre_rst_busy", {63'h0, Busy}, 64'd1);
    chk("pre_rst_zlo", {32'h0, ZLO}, 64'd12);
    Reset = 1'b0;
    #1;
    chk("rst_mid_zlo", {32'h0, ZLO}, 64'd0);
    chk("rst_mid_zhi", {32'h0, ZHI}, 64'd0);
    chk("rst_mid_flags", {61'h0, Busy, Done, DivByZero}, 64'h0);
    @(negedge Clock);
    Reset = 1'b1;
    ndone = 0; nbusy = 0;
    repeat (50) begin
      @(negedge Clock);
      if (Done) ndone++;
      if (Busy) nbusy++;
    end
    chk("post_rst_done", 64'(ndone), 64'd0);
    chk("post_rst_busy", 64'(nbusy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative signed multiply/divide unit on the datapath side of `control_unit`. It consumes the one-cycle MUL/DIV strobes the control unit raises during execute states and computes a 64-bit result. The result is held in ZHI:ZLO for the control unit's later ZHIout/ZLOout steps. Busy/Done let the control unit's state machine stall in a wait state until the result is valid.

## Interface
- `DATA_W`, 32: operand width. The result is 2×DATA_W. The iteration counter is $clog2(DATA_W) bits.
- `Clock`  in  1  rising-edge clock; the only clock in the block.
- `Reset`  in  1  asynchronous, active-low reset (0 = reset).
- `MUL`  in  1  start signed multiply; sampled only in IDLE.
- `DIV`  in  1  start signed divide; sampled only in IDLE.
- `A`  in  DATA_W  multiplicand or dividend, taken from the Y register.
- `B`  in  DATA_W  multiplier or divisor, taken from the bus.
- `ZHI`  out  DATA_W  product high word, or remainder.
- `ZLO`  out  DATA_W  product low word, or quotient.
- `Busy`  out  1  high from the cycle after start through the Done cycle.
- `Done`  out  1  one-cycle pulse; ZHI/ZLO are valid from this cycle on.
- `DivByZero`  out  1  high together with Done when the divisor is 0; otherwise 0.

## Operation
- Reset values: ZHI=0, ZLO=0, Busy=0, Done=0, DivByZero=0, state=IDLE, counter=0.
- States and transitions:
  - IDLE → MUL_RUN on MUL.
  - IDLE → DIV_RUN on DIV with B≠0.
  - IDLE → DONE on DIV with B=0.
  - MUL_RUN → DONE after DATA_W iterations.
  - DIV_RUN → DIV_FIX after DATA_W iterations.
  - DIV_FIX → DONE.
  - DONE → IDLE.
- Start edge: A and B are latched and the counter is cleared. Later changes on A/B have no effect.
- MUL: radix-2 Booth algorithm on two's-complement operands.
  - Each iteration examines {P[0], q-1}, adds or subtracts the multiplicand into the DATA_W+1-bit upper accumulator, then arithmetic-shifts right by 1.
  - Result is the full signed product, with no overflow possible: ZHI:ZLO = A×B.
- DIV: restoring division on magnitudes |A| and |B|, treated as DATA_W-bit unsigned values.
  - Each iteration shifts the {R,Q} pair left, performs a trial subtraction of |B| from R, restores R if the result is negative, and sets the quotient bit.
  - DIV_FIX negates Q if sign(A)≠sign(B), and negates R if A is negative.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend. ZLO = quotient, ZHI = remainder.
- Special cases:
  - A = −2^(DATA_W−1), B = −1: ZLO = 0x80000000, ZHI = 0 (natural wrap, no flag).
  - B = 0: ZLO = 0xFFFFFFFF, ZHI = A, DivByZero = 1, with no iterations performed.
- ZHI/ZLO are written only on the edge entering DONE. They hold that value until the next DONE or reset, so intermediate iterations are never visible on the outputs.
- MUL and DIV both high in IDLE: MUL wins and DIV is ignored.
- MUL/DIV asserted while Busy: ignored, and not queued.
- Reset asserted mid-operation: the operation aborts immediately; all outputs and state return to their reset values.

## Timing
- Start edge is E0, the edge at which MUL/DIV is sampled high in IDLE.
- MUL: iterations on E1..E32; DONE is entered on E32. Done is high in the cycle after E32, i.e. 33 cycles after the start strobe.
- DIV: iterations on E1..E32, DIV_FIX on E33, DONE entered on E33. Done is high 34 cycles after start.
- DIV by zero: DONE is entered on E0. Done is high in the next cycle (1 cycle latency), and Busy is high only in that cycle.
- Back-to-back operation: a new start is accepted in the cycle after Done, once back in IDLE. The earliest new E0 is the edge following the Done cycle.
- All outputs are registered, with no combinational path from the inputs.

## Configuration
- `MULDIV_DIV_EN`
  - Defined: divider datapath, DIV_RUN and DIV_FIX are present, as described above.
  - Undefined: divider logic is omitted. DIV is handled like divide-by-zero timing: Done after 1 cycle, ZHI = ZLO = 0, DivByZero = 0. MUL behaviour is unchanged.

## Test plan
- MUL, A=7, B=−3 → Done 33 cycles later, ZHI=0xFFFFFFFF, ZLO=0xFFFFFFEB, Busy high for exactly 33 cycles.
- MUL, A=B=0x80000000 → ZHI=0x40000000, ZLO=0x00000000, DivByZero=0.
- DIV, A=−7, B=2 → Done 34 cycles later, ZLO=0xFFFFFFFD, ZHI=0xFFFFFFFF. Then DIV, A=0x80000000, B=−1 → ZLO=0x80000000, ZHI=0.
- DIV, A=5, B=0 → Done 1 cycle later, DivByZero=1, ZLO=0xFFFFFFFF, ZHI=5. Then MUL 3×4 → DivByZero=0, ZLO=12.
- MUL and DIV asserted together (A=6, B=3) → product ZLO=18, ZHI=0. A DIV pulse at cycle 10 of that operation is ignored, and there is no second Done.
- Reset driven low at cycle 15 of a MUL (previous result ZLO=12) → ZHI=ZLO=0, Busy=0 immediately. After release, no Done appears without a new start.
